// File: rtl/lif_neuron_core_pkg.sv
// +--------------------------------------------------------------------+
// | lif_neuron_core_pkg: shared state encodings and default constants   |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package lif_neuron_core_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_INTEGRATE = 2'd1;
    localparam state_t ST_REFRACT   = 2'd2;

    localparam int unsigned C_VW_DEFAULT   = 16;
    localparam int unsigned C_VTH_DEFAULT  = 4096;
    localparam int unsigned C_TREF_DEFAULT = 3;

    // A zero-length refractory still needs a 1-bit counter to keep the RTL legal.
    function automatic int ref_width(input int t_ref);
        return (t_ref > 0) ? $clog2(t_ref + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_leak_integrate.sv
// +--------------------------------------------------------------------+
// | lif_leak_integrate: combinational leak + weighted input, saturated  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module lif_leak_integrate #(
    parameter int          VW         = 16,
    parameter int          GAIN_SHIFT = 4,
    parameter int          LEAK_SHIFT = 4,
    parameter int unsigned V_TH       = 4096
) (
    input  logic [VW-1:0] i_v,
    input  logic [7:0]    i_in,
    output logic [VW-1:0] o_sum,
    output logic          o_fire
);

    // Wide enough that neither the weighted input nor v can overflow before saturation.
    localparam int SW = ((VW > 8 + GAIN_SHIFT) ? VW : 8 + GAIN_SHIFT) + 1;
    localparam logic [SW-1:0] C_MAX = {{(SW-VW){1'b0}}, {VW{1'b1}}};

    logic [VW-1:0] w_shifted;
    logic [VW-1:0] w_leak;
    logic [SW-1:0] w_sum_wide;

    always_comb begin
        w_shifted  = i_v >> LEAK_SHIFT;
        w_leak     = w_shifted | {{(VW-1){1'b0}}, ((i_v != '0) && (w_shifted == '0))};
        w_sum_wide = SW'(i_v) - SW'(w_leak) + (SW'(i_in) << GAIN_SHIFT);
        o_sum      = (w_sum_wide > C_MAX) ? {VW{1'b1}} : w_sum_wide[VW-1:0];
        o_fire     = (o_sum >= VW'(V_TH));
    end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_core.sv
// +--------------------------------------------------------------------+
// | lif_neuron_core: leaky integrate-and-fire neuron with refractory    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module lif_neuron_core
    import lif_neuron_core_pkg::*;
#(
    parameter int          VW         = 16,
    parameter int          GAIN_SHIFT = 4,
    parameter int          LEAK_SHIFT = 4,
    parameter int unsigned V_TH       = 4096,
    parameter int unsigned V_RESET    = 0,
    parameter int unsigned T_REF      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_1k,
    input  logic          en,
    input  logic [7:0]    i_in,
    output logic          spike,
    output logic [VW-1:0] v_mem,
    output logic          refractory,
    output logic [15:0]   spike_cnt
);

    localparam int REF_W = ref_width(T_REF);

    state_t            state_q, state_d;
    logic [VW-1:0]     v_q, v_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              spike_q, spike_d;
    logic [15:0]       spike_cnt_q, spike_cnt_d;

    logic [VW-1:0]     w_sum;
    logic              w_fire;

    lif_leak_integrate #(
        .VW         (VW),
        .GAIN_SHIFT (GAIN_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT),
        .V_TH       (V_TH)
    ) u_leak_integrate (
        .i_v    (v_q),
        .i_in   (i_in),
        .o_sum  (w_sum),
        .o_fire (w_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            ref_cnt_q   <= '0;
            spike_q     <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            ref_cnt_q   <= ref_cnt_d;
            spike_q     <= spike_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_INTEGRATE;
                ST_INTEGRATE: if (tick_1k && w_fire && (T_REF != 0)) state_d = ST_REFRACT;
                ST_REFRACT:   if (tick_1k && (ref_cnt_q <= REF_W'(1))) state_d = ST_INTEGRATE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath updates; disable wins over any tick and clears everything but the spike count.
    always_comb begin
        v_d         = v_q;
        ref_cnt_d   = ref_cnt_q;
        spike_d     = 1'b0;
        spike_cnt_d = spike_cnt_q;
        if (!en) begin
            v_d       = '0;
            ref_cnt_d = '0;
        end else if (tick_1k) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (w_fire) begin
                        spike_d     = 1'b1;
                        v_d         = VW'(V_RESET);
                        spike_cnt_d = spike_cnt_q + 16'd1;
                        ref_cnt_d   = REF_W'(T_REF);
                    end else begin
                        v_d = w_sum;
                    end
                end
                ST_REFRACT: begin
                    v_d       = VW'(V_RESET);
                    ref_cnt_d = (ref_cnt_q != '0) ? ref_cnt_q - REF_W'(1) : '0;
                end
                default: ;
            endcase
        end
    end

    assign spike      = spike_q;
    assign v_mem      = v_q;
    assign refractory = (state_q == ST_REFRACT);
    assign spike_cnt  = spike_cnt_q;

endmodule

`default_nettype wire
